// File: rtl/rx_control_frame_module_if.sv
// Receiver-side signal bundle: line and enable in, received word and status out.
// master drives the line/enable (link side); slave is the receiver.
interface rx_control_frame_module_if #(
  parameter int DATA_BITS = 32
);
  logic                 Rx_En_Sig;
  logic                 Rx_Pin_In;
  logic [DATA_BITS-1:0] Rx_Data;
  logic                 Rx_Done_Sig;
  logic                 Rx_Frame_Err;
  logic                 Rx_Busy;
  logic                 Bus_Idle;

  modport master (
    output Rx_En_Sig, Rx_Pin_In,
    input  Rx_Data, Rx_Done_Sig, Rx_Frame_Err, Rx_Busy, Bus_Idle
  );

  modport slave (
    input  Rx_En_Sig, Rx_Pin_In,
    output Rx_Data, Rx_Done_Sig, Rx_Frame_Err, Rx_Busy, Bus_Idle
  );
endinterface

// File: rtl/rx_control_frame_module.sv
// Serial frame receiver: start bit, DATA_BITS LSB first, two stop bits; mid-bit sampling and bus-idle detect.
// Optional macro RX_MAJORITY_VOTE_EN: each bit decision is a 2-of-3 vote over the last three rx_s samples.
module rx_control_frame_module #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 32,
  parameter int IDLE_BITS    = 11
) (
  input  logic                     CLK,
  input  logic                     RSTn,
  rx_control_frame_module_if.slave rx_if
);
  localparam int CW       = $clog2(CLKS_PER_BIT);
  localparam int HALF     = CLKS_PER_BIT / 2;
  localparam int IW       = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int IDLE_SAT = IDLE_BITS * CLKS_PER_BIT;
  localparam int ICW      = $clog2(IDLE_SAT + 1);

  localparam logic [CW-1:0]  CNT_HALF = CW'(HALF - 1);
  localparam logic [CW-1:0]  CNT_BIT  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0]  IDX_LAST = IW'(DATA_BITS - 1);
  localparam logic [ICW-1:0] IDLE_MAX = ICW'(IDLE_SAT);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP1,
    STOP2,
    DONE
  } state_t;

  state_t               state_reg, state_next;
  logic                 sync1_reg;
  logic                 rx_s;
  logic                 rx_d;
  logic [CW-1:0]        cnt_reg, cnt_next;
  logic [IW-1:0]        idx_reg, idx_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 err_reg, err_next;
  logic [DATA_BITS-1:0] data_reg, data_next;
  logic                 ferr_reg, ferr_next;
  logic [ICW-1:0]       idle_cnt_reg, idle_cnt_next;
  logic                 fell;
  logic                 bit_val;

  // Two-flop synchroniser plus one delay stage for falling-edge detection
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      sync1_reg <= 1'b1;
      rx_s      <= 1'b1;
      rx_d      <= 1'b1;
    end else begin
      sync1_reg <= rx_if.Rx_Pin_In;
      rx_s      <= sync1_reg;
      rx_d      <= rx_s;
    end
  end

  assign fell = rx_d & ~rx_s;

`ifdef RX_MAJORITY_VOTE_EN
  logic rx_d2;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      rx_d2 <= 1'b1;
    end else begin
      rx_d2 <= rx_d;
    end
  end

  // rx_d2/rx_d/rx_s are the samples at nominal count -2/-1/0
  assign bit_val = (rx_d2 & rx_d) | (rx_d2 & rx_s) | (rx_d & rx_s);
`else
  assign bit_val = rx_s;
`endif

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      idx_reg      <= '0;
      shift_reg    <= '0;
      err_reg      <= 1'b0;
      data_reg     <= '0;
      ferr_reg     <= 1'b0;
      idle_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      idx_reg      <= idx_next;
      shift_reg    <= shift_next;
      err_reg      <= err_next;
      data_reg     <= data_next;
      ferr_reg     <= ferr_next;
      idle_cnt_reg <= idle_cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + CW'(1);
    idx_next   = idx_reg;
    shift_next = shift_reg;
    err_next   = err_reg;
    data_next  = data_reg;
    ferr_next  = ferr_reg;

    if (!rx_if.Rx_En_Sig) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (fell) begin
            state_next = START;
            err_next   = 1'b0;
          end
        end
        START: begin
          if (cnt_reg == CNT_HALF) begin
            state_next = bit_val ? IDLE : DATA;
            idx_next   = '0;
          end
        end
        DATA: begin
          if (cnt_reg == CNT_BIT) begin
            shift_next = {bit_val, shift_reg[DATA_BITS-1:1]};
            idx_next   = idx_reg + IW'(1);
            if (idx_reg == IDX_LAST) begin
              state_next = STOP1;
            end
          end
        end
        STOP1: begin
          if (cnt_reg == CNT_BIT) begin
            err_next   = err_reg | ~bit_val;
            state_next = STOP2;
          end
        end
        STOP2: begin
          // Word and error are published on entry to DONE so they are valid alongside the pulse
          if (cnt_reg == CNT_BIT) begin
            data_next  = shift_reg;
            ferr_next  = err_reg | ~bit_val;
            state_next = DONE;
          end
        end
        DONE: begin
          err_next   = 1'b0;
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end

    if (state_next != state_reg) begin
      cnt_next = '0;
    end
  end

  always_comb begin
    idle_cnt_next = '0;
    if ((state_reg == IDLE) && rx_s) begin
      idle_cnt_next = (idle_cnt_reg == IDLE_MAX) ? idle_cnt_reg : idle_cnt_reg + ICW'(1);
    end
  end

  assign rx_if.Rx_Data      = data_reg;
  assign rx_if.Rx_Frame_Err = ferr_reg;
  assign rx_if.Rx_Done_Sig  = (state_reg == DONE);
  assign rx_if.Rx_Busy      = (state_reg != IDLE);
  assign rx_if.Bus_Idle     = (state_reg == IDLE) && (idle_cnt_reg == IDLE_MAX);
endmodule

// File: tb/tb_rx_control_frame_module.sv
// Bench for rx_control_frame_module: cycle-offset frame model checked every cycle, plus literal frame checks.
`timescale 1ns/1ps
module tb_rx_control_frame_module;
  localparam int CPB       = 8;
  localparam int IDLE_BITS = 11;
  localparam int DATA_BITS = 32;
  localparam int HALF      = CPB / 2;
  localparam int IDLE_SAT  = IDLE_BITS * CPB;
  localparam int DONE_OFS  = HALF + (DATA_BITS + 2) * CPB + 1;
  localparam int NCYC      = 8192;

  logic CLK  = 1'b0;
  logic RSTn = 1'b0;

  rx_control_frame_module_if #(.DATA_BITS(DATA_BITS)) rx_if ();

  rx_control_frame_module #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (DATA_BITS),
    .IDLE_BITS   (IDLE_BITS)
  ) dut (
    .CLK  (CLK),
    .RSTn (RSTn),
    .rx_if(rx_if.slave)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic pin_arr  [NCYC];
  logic rs_arr   [NCYC];
  logic busy_arr [NCYC];
  logic bi_arr   [NCYC];

  int          done_cnt = 0;
  int          done_cyc = -1;
  logic [31:0] done_data = '0;
  logic        done_err = 1'b0;

  // Model state describes what the outputs must be in the current cycle
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic        m_ferr = 1'b0;
  logic        m_err  = 1'b0;
  logic [31:0] m_data = '0;
  logic [31:0] m_shift = '0;
  int          m_t0 = 0;
  int          m_run = 0;

  task automatic chk_bit(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0b expected %0b", name, cyc, act, exp);
    end
  endtask

  task automatic chk_word(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic decide(input int c);
`ifdef RX_MAJORITY_VOTE_EN
    int ones;
    ones = int'(rs_arr[c-2]) + int'(rs_arr[c-1]) + int'(rs_arr[c]);
    return (ones >= 2);
`else
    return rs_arr[c];
`endif
  endfunction

  // Per-cycle model and compare; the synchronised line is the pin two cycles earlier
  initial begin : model
    int k;
    int j;
    logic d;
    forever begin
      @(negedge CLK);
      if (cyc >= NCYC) begin
        $display("FAIL cycle_budget: got %0d limit %0d", cyc, NCYC);
        $fatal(1, "cycle budget exhausted");
      end
      pin_arr[cyc]  = rx_if.Rx_Pin_In;
      busy_arr[cyc] = rx_if.Rx_Busy;
      bi_arr[cyc]   = rx_if.Bus_Idle;
      if (rx_if.Rx_Done_Sig) begin
        done_cnt++;
        done_cyc  = cyc;
        done_data = rx_if.Rx_Data;
        done_err  = rx_if.Rx_Frame_Err;
        $display("[TB] cycle %0d frame received data=%h err=%0b", cyc, done_data, done_err);
      end
      if (!RSTn) begin
        rs_arr[cyc] = 1'b1;
        m_busy = 1'b0; m_done = 1'b0; m_ferr = 1'b0; m_err = 1'b0;
        m_data = '0;   m_run = 0;
        chk_bit("rst_busy", rx_if.Rx_Busy, 1'b0);
        chk_bit("rst_done", rx_if.Rx_Done_Sig, 1'b0);
        chk_bit("rst_ferr", rx_if.Rx_Frame_Err, 1'b0);
        chk_bit("rst_bus_idle", rx_if.Bus_Idle, 1'b0);
        chk_word("rst_data", rx_if.Rx_Data, 32'h0);
      end else begin
        rs_arr[cyc] = (cyc >= 2) ? pin_arr[cyc-2] : 1'b1;
        chk_bit("model_busy", rx_if.Rx_Busy, m_busy);
        chk_bit("model_done", rx_if.Rx_Done_Sig, m_done);
        chk_bit("model_ferr", rx_if.Rx_Frame_Err, m_ferr);
        chk_word("model_data", rx_if.Rx_Data, m_data);
        chk_bit("model_bus_idle", rx_if.Bus_Idle, !m_busy && (m_run == IDLE_SAT));

        m_done = 1'b0;
        if (!m_busy && rs_arr[cyc]) m_run = (m_run < IDLE_SAT) ? m_run + 1 : IDLE_SAT;
        else                        m_run = 0;

        if (!m_busy) begin
          if (rx_if.Rx_En_Sig && cyc >= 1 && rs_arr[cyc-1] && !rs_arr[cyc]) begin
            m_busy = 1'b1;
            m_t0   = cyc;
            m_err  = 1'b0;
          end
        end else begin
          k = cyc - m_t0;
          if (!rx_if.Rx_En_Sig || k >= DONE_OFS) begin
            m_busy = 1'b0;
          end else if (k == HALF) begin
            if (decide(cyc)) m_busy = 1'b0;
          end else if (k > HALF && ((k - HALF) % CPB) == 0) begin
            j = (k - HALF) / CPB;
            d = decide(cyc);
            if (j <= DATA_BITS) begin
              m_shift[j-1] = d;
            end else begin
              if (!d) m_err = 1'b1;
              if (j == DATA_BITS + 2) begin
                m_data = m_shift;
                m_ferr = m_err;
                m_done = 1'b1;
              end
            end
          end
        end
      end
      cyc++;
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic hold(input logic v, input int n);
    rx_if.Rx_Pin_In = v;
    repeat (n) step();
  endtask

  // gbit >= 0 pulls that data bit low for one cycle exactly at its mid-bit sample
  task automatic send_frame(input logic [31:0] d, input logic s2, input int gbit, output int fall);
    fall = cyc;
    hold(1'b0, CPB);
    for (int i = 0; i < DATA_BITS; i++) begin
      for (int n = 0; n < CPB; n++) begin
        rx_if.Rx_Pin_In = (i == gbit && n == HALF) ? 1'b0 : d[i];
        step();
      end
    end
    hold(1'b1, CPB);
    hold(s2, CPB);
    hold(1'b1, 20);
  endtask

  task automatic frame_check(input string name, input int base_cnt, input int fall,
                             input logic [31:0] exp_d, input logic exp_e);
    chk_int({name, "_done_count"}, done_cnt - base_cnt, 1);
    // 2 synchroniser cycles plus HALF + 34*CPB + 1 = 277 from the edge on rx_s
    chk_int({name, "_latency"}, done_cyc - fall, 2 + 277);
    chk_word({name, "_data"}, done_data, exp_d);
    chk_bit({name, "_err"}, done_err, exp_e);
  endtask

  initial begin : stim
    int fall;
    int base;
    int busy_n;
    rx_if.Rx_En_Sig = 1'b1;
    rx_if.Rx_Pin_In = 1'b1;
    RSTn = 1'b0;
    repeat (3) step();
    chk_word("reset_data", rx_if.Rx_Data, 32'h0);
    chk_bit("reset_busy", rx_if.Rx_Busy, 1'b0);
    RSTn = 1'b1;

    // Line high from reset: Bus_Idle after exactly 88 cycles
    repeat (87) step();
    chk_bit("bus_idle_87", rx_if.Bus_Idle, 1'b0);
    step();
    chk_bit("bus_idle_88", rx_if.Bus_Idle, 1'b1);

    // Clean frame; Bus_Idle drops the cycle START is entered
    base = done_cnt;
    send_frame(32'hA5C3_0F81, 1'b1, -1, fall);
    frame_check("clean", base, fall, 32'hA5C3_0F81, 1'b0);
    chk_bit("bus_idle_before_start", bi_arr[fall+2], 1'b1);
    chk_bit("bus_idle_at_start", bi_arr[fall+3], 1'b0);

    // Bad STOP2 then a clean frame clears the error
    base = done_cnt;
    send_frame(32'h0000_0001, 1'b0, -1, fall);
    frame_check("stop2_err", base, fall, 32'h0000_0001, 1'b1);
    base = done_cnt;
    send_frame(32'h1234_5678, 1'b1, -1, fall);
    frame_check("err_clear", base, fall, 32'h1234_5678, 1'b0);

    // Two-cycle low pulse: start rejected, busy for HALF cycles only
    base = done_cnt;
    fall = cyc;
    hold(1'b0, 2);
    hold(1'b1, 24);
    busy_n = 0;
    for (int i = 0; i < 24; i++) busy_n += int'(busy_arr[fall+i]);
    chk_int("glitch_busy_cycles", busy_n, HALF);
    chk_int("glitch_no_done", done_cnt - base, 0);

    // Enable dropped inside data bit 10
    base = done_cnt;
    hold(1'b0, CPB);
    for (int i = 0; i < 10; i++) hold(i[0], CPB);
    hold(1'b1, 3);
    chk_bit("abort_busy_before", rx_if.Rx_Busy, 1'b1);
    rx_if.Rx_En_Sig = 1'b0;
    step();
    chk_bit("abort_busy_after", rx_if.Rx_Busy, 1'b0);
    hold(1'b1, 30);
    rx_if.Rx_En_Sig = 1'b1;
    hold(1'b1, 20);
    chk_int("abort_no_done", done_cnt - base, 0);
    chk_word("abort_data_kept", rx_if.Rx_Data, 32'h1234_5678);

    // Asynchronous reset in the middle of DATA
    hold(1'b0, CPB);
    hold(1'b1, 5 * CPB);
    chk_bit("midreset_busy_before", rx_if.Rx_Busy, 1'b1);
    #1 RSTn = 1'b0;
    #1;
    chk_bit("midreset_busy", rx_if.Rx_Busy, 1'b0);
    chk_word("midreset_data", rx_if.Rx_Data, 32'h0);
    chk_bit("midreset_done", rx_if.Rx_Done_Sig, 1'b0);
    chk_bit("midreset_ferr", rx_if.Rx_Frame_Err, 1'b0);
    repeat (3) step();
    RSTn = 1'b1;
    hold(1'b1, 20);
    base = done_cnt;
    send_frame(32'hFFFF_FFFF, 1'b1, -1, fall);
    frame_check("after_reset", base, fall, 32'hFFFF_FFFF, 1'b0);

    // One-cycle low glitch exactly at the mid-bit sample of data bit 5
    base = done_cnt;
    send_frame(32'hFFFF_FFFF, 1'b1, 5, fall);
`ifdef RX_MAJORITY_VOTE_EN
    frame_check("midbit_glitch", base, fall, 32'hFFFF_FFFF, 1'b0);
`else
    frame_check("midbit_glitch", base, fall, 32'hFFFF_FFDF, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
